// File: rtl/chronos_lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
// State encoding, RV32I access widths, fault codes and legality helpers.
package chronos_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_ILLEGAL  = 2'b10;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b11;

    function automatic logic f3_legal(input logic [2:0] f3);
        return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic logic f3_misaligned(
        input logic [2:0] f3,
        input logic [1:0] off
    );
        return ((f3[1:0] == 2'b01) && off[0])
            || ((f3[1:0] == 2'b10) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the load/store unit.
// Builds store masks/replicated data and extracts/extends load data.
module lsu_lane_align
    import chronos_lsu_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [3:0]  st_mask,
    output logic [31:0] st_wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign ld_byte = ld_rdata[{ld_off, 3'b000} +: 8];
    assign ld_half = ld_rdata[{ld_off[1], 4'b0000} +: 16];

    // Store side: replicate data across lanes and enable only the target lanes.
    always_comb begin
        st_mask  = 4'b0000;
        st_wdata = 32'h0;
        case (st_funct3[1:0])
            2'b00: begin
                st_mask  = 4'b0001 << st_off;
                st_wdata = {4{st_data[7:0]}};
            end
            2'b01: begin
                st_mask  = 4'b0011 << {st_off[1], 1'b0};
                st_wdata = {2{st_data[15:0]}};
            end
            default: begin
                st_mask  = 4'b1111;
                st_wdata = st_data;
            end
        endcase
    end

    // Load side: pick the addressed lane, then sign- or zero-extend.
    always_comb begin
        ld_data = ld_rdata;
        case (ld_funct3)
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_BU:   ld_data = {24'h0, ld_byte};
            F3_HU:   ld_data = {16'h0, ld_half};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one access at a time to simulated_mem.
// Stalls the pipeline while busy, reports misalign/illegal/timeout faults.
module mem_stage_lsu
    import chronos_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_enable,
    output logic        mem_cmd,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_mask,
    input  logic        mem_valid,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic        done,
    output logic        wb_en,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        fault_valid,
    output logic [1:0]  fault_code
);

    localparam logic [7:0] TO_CNT = 8'(TIMEOUT_CYCLES);

    lsu_state_e  state;
    logic [7:0]  cnt;
    logic        op_write;
    logic [2:0]  op_funct3;
    logic [1:0]  op_off;
    logic [4:0]  op_rd;

    logic        slot;
    logic        busy;
    logic        legal;
    logic        accept;
    logic        reject;
    logic        to_hit;
    logic [3:0]  st_mask;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;

    assign slot   = (state == ST_IDLE) || (state == ST_RESP);
    assign busy   = (state == ST_REQ) || (state == ST_WAIT);
    assign legal  = f3_legal(req_funct3)
                 && !f3_misaligned(req_funct3, req_addr[1:0]);
    assign accept = slot && req_valid && legal;
    assign reject = slot && req_valid && !legal;
    assign to_hit = (cnt + 8'd1) == TO_CNT;
    assign stall  = accept || busy;

    lsu_lane_align u_align (
        .st_funct3 (req_funct3),
        .st_off    (req_addr[1:0]),
        .st_data   (req_wdata),
        .st_mask   (st_mask),
        .st_wdata  (st_wdata),
        .ld_funct3 (op_funct3),
        .ld_off    (op_off),
        .ld_rdata  (mem_rdata),
        .ld_data   (ld_data)
    );

    // Access FSM with timeout counter and registered bus/writeback/fault outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            cnt         <= 8'd0;
            op_write    <= 1'b0;
            op_funct3   <= 3'b000;
            op_off      <= 2'b00;
            op_rd       <= 5'd0;
            mem_enable  <= 1'b0;
            mem_cmd     <= 1'b0;
            mem_addr    <= 32'h0;
            mem_wdata   <= 32'h0;
            mem_mask    <= 4'h0;
            done        <= 1'b0;
            wb_en       <= 1'b0;
            wb_rd       <= 5'd0;
            wb_data     <= 32'h0;
            fault_valid <= 1'b0;
            fault_code  <= FAULT_NONE;
        end else begin
            mem_enable  <= 1'b0;
            done        <= 1'b0;
            wb_en       <= 1'b0;
            fault_valid <= 1'b0;
            case (state)
                ST_IDLE, ST_RESP: begin
                    if (accept) begin
                        op_write   <= req_write;
                        op_funct3  <= req_funct3;
                        op_off     <= req_addr[1:0];
                        op_rd      <= req_rd;
                        mem_enable <= 1'b1;
                        mem_cmd    <= req_write;
                        mem_addr   <= {req_addr[31:2], 2'b00};
                        mem_mask   <= req_write ? st_mask : 4'h0;
                        mem_wdata  <= req_write ? st_wdata : 32'h0;
                        cnt        <= 8'd0;
                        state      <= ST_REQ;
                    end else begin
                        state <= ST_IDLE;
                        if (reject) begin
                            fault_valid <= 1'b1;
                            fault_code  <= f3_legal(req_funct3)
                                         ? FAULT_MISALIGN
                                         : FAULT_ILLEGAL;
                        end
                    end
                end
                ST_REQ, ST_WAIT: begin
                    if (mem_valid) begin
                        done    <= 1'b1;
                        wb_rd   <= op_rd;
                        wb_data <= op_write ? 32'h0 : ld_data;
                        wb_en   <= !op_write && (op_rd != 5'd0);
                        state   <= ST_RESP;
                    end else if (to_hit) begin
                        fault_valid <= 1'b1;
                        fault_code  <= FAULT_TIMEOUT;
                        state       <= ST_IDLE;
                    end else begin
                        cnt   <= cnt + 8'd1;
                        state <= ST_WAIT;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
